// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared constants for the program ROM fetch path: geometry, reset PC, FSM encoding.
// Latency: n/a. Backpressure: n/a.
// Geometry defaults match the 4K x 8 program ROM.
package rom_fetch_sequencer_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_DATA_W = 8;

    localparam logic [ROM_ADDR_W-1:0] DEFAULT_RESET_PC = 12'h000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

endpackage

// File: rtl/rom_fetch_sequencer_pc_counter.sv
// Program counter register with jump load, increment and wrap pulse.
// Latency: pc and wrap update one edge after load/inc.
// Backpressure: none; the caller gates inc. Load always wins over inc.
module pc_counter #(
    parameter int W = 12,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_addr,
    input  logic         inc,
    output logic [W-1:0] pc,
    output logic         wrap
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc   <= RESET_PC;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                // A jump to 0 is not a roll-over, so wrap stays low.
                pc <= load_addr;
            end else if (inc) begin
                pc   <= pc + W'(1);
                wrap <= &pc;
            end
        end
    end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// PC/fetch controller for the program ROM; presents {instr,oprnd} to decode.
// Latency: ROM_LAT+1 edges from leaving IDLE to instr_valid; one word per ROM_LAT+2 cycles.
// Backpressure: word held stable while instr_ready=0; load drops or redirects it.
module rom_fetch_sequencer
    import rom_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DATA_W  = ROM_DATA_W,
    parameter int ROM_LAT = 0,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [ADDR_W-1:0]   load_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [DATA_W/2-1:0] instr,
    output logic [DATA_W/2-1:0] oprnd,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                pc_wrap
);

    localparam int         HALF = DATA_W / 2;
    localparam logic [1:0] LAT  = 2'(ROM_LAT);

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    // Advance only on a completed handshake that is not redirected by a jump.
    assign pc_inc   = (state == ST_VALID) && instr_ready && !load;
    assign rom_addr = pc;

    pc_counter #(
        .W        (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_addr (load_addr),
        .inc       (pc_inc),
        .pc        (pc),
        .wrap      (pc_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            oprnd       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_FETCH;
                        cnt   <= '0;
                    end
                end
                ST_FETCH: begin
                    // A jump restarts the ROM wait against the new address.
                    if (load) begin
                        cnt <= '0;
                    end else if (cnt == LAT) begin
                        instr       <= rom_data[DATA_W-1:HALF];
                        oprnd       <= rom_data[HALF-1:0];
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_VALID;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_VALID: begin
                    if (instr_ready || load) begin
                        instr_valid <= 1'b0;
                        cnt         <= '0;
                        state       <= enable ? ST_FETCH : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Scoreboard bench: two sequencers (ROM_LAT 0 and 2) on shared random/directed stimulus.
module tb_rom_fetch_sequencer;

    localparam int LAT0 = 0;
    localparam int LAT1 = 2;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [11:0] load_addr;
    logic        instr_ready;

    logic [11:0] rom_addr [2];
    logic [7:0]  rom_data [2];
    logic        iv       [2];
    logic [3:0]  ins      [2];
    logic [3:0]  opr      [2];
    logic [11:0] ipc      [2];
    logic        wrp      [2];

    logic [7:0]  mem [4096];
    logic [7:0]  d1, d2;

    // Reference model state, per instance
    logic [11:0] m_pc    [2];
    bit          m_have  [2];
    bit          m_fetch [2];
    int          m_left  [2];
    bit          m_wrap  [2];
    int          acc_cnt [2];
    int          wrap_cnt[2];
    logic [19:0] q0 [$];
    logic [19:0] q1 [$];

    int n_chk;
    int n_pass;

    rom_fetch_sequencer #(.ROM_LAT(LAT0)) u_lat0 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .load_addr(load_addr),
        .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .instr_valid(iv[0]),
        .instr_ready(instr_ready), .instr(ins[0]), .oprnd(opr[0]),
        .instr_pc(ipc[0]), .pc_wrap(wrp[0])
    );

    rom_fetch_sequencer #(.ROM_LAT(LAT1)) u_lat2 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .load_addr(load_addr),
        .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .instr_valid(iv[1]),
        .instr_ready(instr_ready), .instr(ins[1]), .oprnd(opr[1]),
        .instr_pc(ipc[1]), .pc_wrap(wrp[1])
    );

    // Combinational ROM for instance 0; two-stage registered ROM for instance 1
    assign rom_data[0] = mem[rom_addr[0]];
    always @(posedge clk) begin
        d1 <= mem[rom_addr[1]];
        d2 <= d1;
    end
    assign rom_data[1] = d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, got, exp, $time);
    endtask

    task automatic push(input int i, input logic [19:0] w);
        if (i == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [19:0] qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]    = 12'h000;
            m_have[i]  = 1'b0;
            m_fetch[i] = 1'b0;
            m_left[i]  = 0;
            m_wrap[i]  = 1'b0;
            acc_cnt[i] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Behavioural rules applied at one rising edge, using the inputs seen there.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit wn;
            int lat;
            wn  = 1'b0;
            lat = (i == 0) ? LAT0 : LAT1;
            if (m_have[i]) begin
                if (load) m_pc[i] = load_addr;
                else if (instr_ready) begin
                    wn = (m_pc[i] == 12'hFFF);
                    m_pc[i] = m_pc[i] + 12'd1;
                end
                if (load || instr_ready) begin
                    m_have[i]  = 1'b0;
                    m_fetch[i] = enable;
                    m_left[i]  = lat;
                end
            end else if (m_fetch[i]) begin
                if (load) begin
                    m_pc[i]   = load_addr;
                    m_left[i] = lat;
                end else if (m_left[i] == 0) begin
                    push(i, {mem[m_pc[i]], m_pc[i]});
                    m_have[i]  = 1'b1;
                    m_fetch[i] = 1'b0;
                end else begin
                    m_left[i] = m_left[i] - 1;
                end
            end else begin
                if (load) m_pc[i] = load_addr;
                if (enable) begin
                    m_fetch[i] = 1'b1;
                    m_left[i]  = lat;
                end
            end
            m_wrap[i] = wn;
        end
    endtask

    task automatic step(input bit en, input bit rdy, input bit ld, input logic [11:0] la);
        enable      = en;
        instr_ready = rdy;
        load        = ld;
        load_addr   = la;
        @(posedge clk);
        if (reset) model_update();
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid",   i, 32'(iv[i]),       32'd0);
            chk("rst_instr",   i, 32'(ins[i]),      32'd0);
            chk("rst_oprnd",   i, 32'(opr[i]),      32'd0);
            chk("rst_instrpc", i, 32'(ipc[i]),      32'd0);
            chk("rst_wrap",    i, 32'(wrp[i]),      32'd0);
            chk("rst_romaddr", i, 32'(rom_addr[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_both_valid();
        int t;
        t = 0;
        while (!(m_have[0] && m_have[1]) && t < 20) begin
            step(1'b1, 1'b0, 1'b0, 12'h000);
            t++;
        end
        if (t >= 20) begin
            n_chk++;
            $display("FAIL wait_valid: no word after %0d cycles, required within 20", t);
        end
    endtask

    // Monitor: per-cycle compare against the model and the expected-word queue.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("valid",    i, 32'(iv[i]),       32'(m_have[i]));
                chk("rom_addr", i, 32'(rom_addr[i]), 32'(m_pc[i]));
                chk("pc_wrap",  i, 32'(wrp[i]),      32'(m_wrap[i]));
                if (wrp[i]) wrap_cnt[i]++;
                if (iv[i]) begin
                    if (qsize(i) == 0) begin
                        n_chk++;
                        $display("FAIL word inst%0d: got %0h%0h@%0h expected no word", i, ins[i], opr[i], ipc[i]);
                    end else begin
                        chk("word", i, 32'({ins[i], opr[i], ipc[i]}), 32'(qfront(i)));
                        if (instr_ready || load) qpop(i);
                    end
                    if (instr_ready) acc_cnt[i]++;
                end
            end
        end
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        wrap_cnt[0] = 0;
        wrap_cnt[1] = 0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        mem[0] = 8'h1A; mem[1] = 8'h2B; mem[2] = 8'h3C; mem[3] = 8'h4D; mem[4] = 8'h5E;
        mem[12'h0FF] = 8'h9F;
        enable = 1'b0; load = 1'b0; load_addr = 12'h000; instr_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Streaming from 0 with ready high: words 1A..5E, one per LAT+2 cycles
        repeat (10) step(1'b1, 1'b1, 1'b0, 12'h000);
        @(negedge clk);
        #1;
        chk("stream_count", 0, 32'(acc_cnt[0]), 32'(10 / (LAT0 + 2)));
        chk("stream_count", 1, 32'(acc_cnt[1]), 32'(10 / (LAT1 + 2)));
        repeat (4) step(1'b1, 1'b1, 1'b0, 12'h000);

        // Stall with ready low, then release
        do_reset();
        wait_both_valid();
        repeat (5) step(1'b1, 1'b0, 1'b0, 12'h000);
        repeat (8) step(1'b1, 1'b1, 1'b0, 12'h000);

        // Jump during FETCH aborts the in-flight word
        do_reset();
        step(1'b1, 1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b1, 1'b1, 12'h0FF);
        repeat (8) step(1'b1, 1'b1, 1'b0, 12'h000);

        // Jump on the same edge as the accept of word 0
        do_reset();
        wait_both_valid();
        step(1'b1, 1'b1, 1'b1, 12'h010);
        repeat (8) step(1'b1, 1'b1, 1'b0, 12'h000);

        // Roll-over from FFF to 000: exactly one wrap pulse
        do_reset();
        step(1'b0, 1'b1, 1'b1, 12'hFFF);
        wrap_cnt[0] = 0;
        wrap_cnt[1] = 0;
        repeat (12) step(1'b1, 1'b1, 1'b0, 12'h000);
        repeat (4) step(1'b0, 1'b1, 1'b0, 12'h000);
        chk("wrap_pulses", 0, 32'(wrap_cnt[0]), 32'd1);
        chk("wrap_pulses", 1, 32'(wrap_cnt[1]), 32'd1);

        // Enable dropped mid-FETCH, then async reset during a later FETCH
        do_reset();
        step(1'b1, 1'b1, 1'b0, 12'h000);
        repeat (6) step(1'b0, 1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b1, 1'b0, 12'h000);
        do_reset();

        // Randomized traffic
        repeat (3000) begin
            bit          en, rdy, ld;
            logic [11:0] la;
            en  = ($urandom_range(3) != 0);
            rdy = ($urandom_range(1) != 0);
            ld  = ($urandom_range(15) == 0);
            case ($urandom_range(3))
                0:       la = 12'hFFF;
                1:       la = 12'hFFE;
                2:       la = 12'h000;
                default: la = 12'($urandom);
            endcase
            if ($urandom_range(299) == 0) do_reset();
            else step(en, rdy, ld, la);
        end
        repeat (2) step(1'b0, 1'b1, 1'b0, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_fetch_sequencer.md
Name: rom_fetch_sequencer

Overview:
- Program-counter and fetch controller that sequences the 4K x 8 program ROM (12-bit address, 8-bit code word).
- Holds the PC and drives the ROM address. It waits the ROM read latency, captures the code word, splits it into instruction and operand nibbles, and hands it to the decode stage over a valid/ready handshake.
- Supports jumps (PC load), run/stop via enable, and reports PC wrap-around.

Parameters:
- ADDR_W, 12, ROM address / PC width.
- DATA_W, 8, ROM word width. Must be even; the upper half is instr and the lower half is oprnd.
- ROM_LAT, 0, number of ROM read wait cycles. Legal range 0..3; 0 means a combinational ROM.
- RESET_PC, 12'h000, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; 0 stops fetching after the current word is delivered.
- load  in  1  jump request, sampled on the clock edge.
- load_addr  in  ADDR_W  jump target.
- rom_addr  out  ADDR_W  address to ROM; always equals the pc register.
- rom_data  in  DATA_W  code word returned by ROM.
- instr_valid  out  1  fetched word available.
- instr_ready  in  1  consumer accepts the word.
- instr  out  DATA_W/2  upper nibble of the captured word.
- oprnd  out  DATA_W/2  lower nibble of the captured word.
- instr_pc  out  ADDR_W  address the presented word came from.
- pc_wrap  out  1  one-cycle pulse when the PC rolls from all-ones to 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - pc=RESET_PC, so rom_addr=RESET_PC.
  - instr_valid=0, instr=0, oprnd=0, instr_pc=0, pc_wrap=0, wait counter=0.
  - This holds mid-fetch as well; any in-flight word is discarded.
- States: IDLE, FETCH, VALID.
- IDLE:
  - load=1 → pc<=load_addr; stay in IDLE unless enable=1, in which case go to FETCH.
  - enable=1 → FETCH, cnt<=0.
- FETCH:
  - Each edge with cnt<ROM_LAT: cnt<=cnt+1.
  - At the edge with cnt==ROM_LAT:
    - {instr,oprnd}<=rom_data; instr_pc<=pc; instr_valid<=1; state → VALID.
  - Enable dropping in FETCH does not abort the fetch.
- VALID:
  - Outputs are held stable while instr_ready=0.
  - On the edge with instr_ready=1:
    - instr_valid<=0.
    - pc<=pc+1, mod 2^ADDR_W.
    - Next state is FETCH if enable=1, else IDLE.
- Timing:
  - Fetch latency from leaving IDLE to instr_valid high is ROM_LAT+1 edges.
  - Throughput with instr_ready tied high is one word per ROM_LAT+2 cycles.
- Load priority: load=1 overrides the pc increment in every state.
  - In FETCH: the in-flight fetch is aborted, pc<=load_addr, cnt<=0, stay in FETCH (restart).
  - In VALID with instr_ready=0: the word is dropped (instr_valid<=0), pc<=load_addr, state → FETCH if enable, else IDLE.
  - In VALID with instr_ready=1 on the same edge: the handshake completes (the word counts as transferred), then pc<=load_addr instead of pc+1.
- Wrap-around: an increment from pc=all-ones gives pc=0 and pc_wrap=1 for exactly one cycle. A load to 0 does not pulse pc_wrap.
- instr_valid never rises without a completed FETCH, and never drops without either a handshake or a load.

Decomposition:
- Shared package/header:
  - State encoding constants ST_IDLE=2'd0, ST_FETCH=2'd1, ST_VALID=2'd2.
  - Default ADDR_W/DATA_W shared with the ROM.
  - RESET_PC constant.
- One natural sub-module, pc_counter: the ADDR_W register with async active-low reset, load, increment, and the wrap pulse. The FSM, wait counter and capture register stay in the top.

Test Plan:
- ROM model with ROM_LAT=0 and mem[0..4]=8'h1A,8'h2B,8'h3C,8'h4D,8'h5E. Release reset, hold enable=1 and instr_ready=1.
  - Required: words 1/A, 2/B, 3/C, 4/D, 5/E with instr_pc 0..4.
  - Required: instr_valid first high 1 edge after leaving IDLE, and one word every 2 cycles.
- ROM_LAT=2; hold instr_ready=0 for 5 cycles after instr_valid rises.
  - Required: first valid 3 edges after leaving IDLE.
  - Required: instr/oprnd/instr_pc stay 1/A/0 throughout the stall.
  - Required: pc advances to 1 only after instr_ready=1.
- load=1 with load_addr=12'h0FF during FETCH, with mem[0FF]=8'h9F.
  - Required: next delivered word is 9/F with instr_pc=0FF; the aborted word is never presented.
- load=1 with load_addr=12'h010 on the same edge as the accept of word 0.
  - Required: word 0 counts as delivered.
  - Required: the next word comes from 0x010, not 0x001.
- load_addr=12'hFFF, then run two fetches.
  - Required: words from 0xFFF then 0x000.
  - Required: pc_wrap high for exactly one cycle, on the increment.
- Drop enable mid-FETCH, then assert reset=0 asynchronously during a later FETCH.
  - Required: the current word is still delivered, then the FSM sits in IDLE with pc+1.
  - Required: on reset, outputs clear immediately without a clock edge, and pc returns to 0.
